tile_read_sched: RTL and testbench
==================================

# tile_read_sched

Sequencer that drives a single tile reader through a multi-tile job: for each tile it clears the reader, waits for the routing stage to accept a new tile, enables the read, and waits for completion. It sits between the layer controller, which issues one job per start pulse, and the tile reader feeding the router. Tile base addresses advance by a programmable stride, modulo buffer depth.

## Interface
- BUF_DEPTH, 64, words in the source buffer; ADDR_WIDTH = $clog2(BUF_DEPTH) (localparam)
- MAX_TILES, 16, maximum tiles per job; TILE_WIDTH = $clog2(MAX_TILES+1) (localparam)

- i_clk  in  1  clock; single clock domain
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  job start pulse; sampled only in IDLE
- i_abort  in  1  terminate job; any non-IDLE state returns to IDLE
- i_base_addr  in  ADDR_WIDTH  start address of tile 0
- i_tile_len  in  ADDR_WIDTH  tile length minus 1 (tile = i_tile_len+1 words)
- i_tile_stride  in  ADDR_WIDTH  address increment between tiles
- i_num_tiles  in  TILE_WIDTH  tiles in job; 0 = empty job
- i_route_ready  in  1  router can accept a new tile
- i_read_done  in  1  reader finished current tile (sticky until cleared)
- o_read_en  out  1  reader enable
- o_reg_clear  out  1  reader clear
- o_start_addr  out  ADDR_WIDTH  current tile base address
- o_addr_end  out  ADDR_WIDTH  current tile length minus 1
- o_tile_idx  out  TILE_WIDTH  index of current tile
- o_tile_start  out  1  one-cycle pulse on the first READ cycle of each tile
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse on normal job completion

## Operation
- Config (base, len, stride, num_tiles) latches on accepted i_start; input changes afterwards are ignored until the next IDLE.
- States: IDLE, CLEAR, WAIT_RDY, READ, NEXT, DONE.
- IDLE: on i_start, go to DONE if i_num_tiles==0, else go to CLEAR. Set cur_addr=i_base_addr and tile_idx=0.
- CLEAR: o_reg_clear=1 for exactly one cycle, then WAIT_RDY.
- WAIT_RDY: hold until i_route_ready=1, then READ. No timeout.
- READ: o_read_en=1 continuously. When i_read_done=1, go to DONE if tile_idx==num_tiles-1, else go to NEXT. i_route_ready is ignored in this state.
- NEXT: cur_addr <= cur_addr + stride, truncated to ADDR_WIDTH (wraps mod BUF_DEPTH); tile_idx <= tile_idx+1; then CLEAR.
- DONE: o_done=1 and o_reg_clear=1 for one cycle, then IDLE.
- i_abort has priority over all transitions in non-IDLE states. Next state is IDLE, o_reg_clear=1 during the abort cycle, and no o_done is generated. i_abort in IDLE has no effect.
- i_start while o_busy=1 is ignored.
- i_num_tiles > MAX_TILES is clamped to MAX_TILES at latch.
- Tile address ranges may exceed BUF_DEPTH; wrap-around within a tile is the reader's concern. This block only wraps the tile base.

## Timing
- All outputs are Moore, decoded from registered state/config. o_start_addr=cur_addr, o_addr_end=latched len, o_tile_idx=tile_idx.
- Reset: state=IDLE; cur_addr, len, stride, num_tiles, tile_idx = 0; every output 0.
- Reset asserted mid-job returns to IDLE on the next edge with no o_done. o_reg_clear is not asserted, because reader reset is separate.
- Latency: i_start at edge N gives CLEAR in cycle N+1 and WAIT_RDY in N+2. With ready held high, READ (o_read_en, o_tile_start) is in N+3.
- Inter-tile overhead: 3 cycles (NEXT, CLEAR, WAIT_RDY with ready=1) between READ exit and next READ entry.
- o_start_addr/o_addr_end are stable from CLEAR through the end of READ of each tile. They change only on the NEXT→CLEAR edge.
- A stale i_read_done is never acted on: CLEAR always precedes READ, and i_read_done is sampled only in READ.
- Empty job: i_start at N gives DONE (o_done, o_reg_clear) in N+1 and IDLE in N+2.

## Test plan
- Single tile: base=4, len=7, num=1, ready=1, done raised 9 cycles after o_read_en -> o_start_addr=4, o_addr_end=7; exactly one o_tile_start; o_done one cycle after done seen; o_busy low after.
- Multi-tile wrap: base=56, stride=8, num=3 -> o_start_addr sequence 56, 0, 8; o_tile_idx 0, 1, 2; three o_reg_clear pulses before reads plus one in DONE.
- Backpressure: i_route_ready low 5 cycles in WAIT_RDY of tile 1 -> o_read_en stays 0 for those 5 cycles, o_start_addr holds, READ starts the cycle after ready rises.
- Empty job and busy start: num=0 -> o_done at N+1 with o_read_en never high; i_start pulsed during a 4-tile job -> ignored, job completes unchanged.
- Abort in READ of tile 2 of 4 -> IDLE next cycle, o_reg_clear=1 that cycle, o_read_en drops, no o_done; a new i_start then runs normally from tile 0.
- Reset mid-job (i_rst in WAIT_RDY) -> all outputs 0 next cycle; num=20 with MAX_TILES=16 -> exactly 16 tiles then o_done.

Source files
------------

// File: rtl/tile_read_sched.sv
// Tile read sequencer: steps one tile reader through a multi-tile job
// (clear, wait for router, read, advance base address by stride mod buffer depth).
module tile_read_sched #(
    parameter  int BUF_DEPTH  = 64,
    parameter  int MAX_TILES  = 16,
    localparam int ADDR_WIDTH = $clog2(BUF_DEPTH),
    localparam int TILE_WIDTH = $clog2(MAX_TILES + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH-1:0] i_tile_len,
    input  logic [ADDR_WIDTH-1:0] i_tile_stride,
    input  logic [TILE_WIDTH-1:0] i_num_tiles,
    input  logic                  i_route_ready,
    input  logic                  i_read_done,
    output logic                  o_read_en,
    output logic                  o_reg_clear,
    output logic [ADDR_WIDTH-1:0] o_start_addr,
    output logic [ADDR_WIDTH-1:0] o_addr_end,
    output logic [TILE_WIDTH-1:0] o_tile_idx,
    output logic                  o_tile_start,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT_RDY,
        ST_READ,
        ST_NEXT,
        ST_DONE
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cur_addr_q;
    logic [ADDR_WIDTH-1:0] cur_addr_d;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [TILE_WIDTH-1:0] num_tiles_q;
    logic [TILE_WIDTH-1:0] num_tiles_d;
    logic [TILE_WIDTH-1:0] tile_idx_q;
    logic                  last_tile;

    logic read_en_q;
    logic reg_clear_q;
    logic tile_start_q;
    logic busy_q;
    logic done_q;

    // Base address wraps mod BUF_DEPTH simply by truncation to ADDR_WIDTH.
    assign cur_addr_d  = cur_addr_q + stride_q;
    assign num_tiles_d = (i_num_tiles > TILE_WIDTH'(MAX_TILES)) ? TILE_WIDTH'(MAX_TILES)
                                                                : i_num_tiles;
    assign last_tile   = (tile_idx_q == num_tiles_q - TILE_WIDTH'(1));

    // NOTE: outputs are flops written together with the state transition, so
    // each one already holds the value for the state being entered (pure Moore,
    // no decode glitches); non-blocking assignments keep every flop sampling
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            cur_addr_q   <= '0;
            len_q        <= '0;
            stride_q     <= '0;
            num_tiles_q  <= '0;
            tile_idx_q   <= '0;
            read_en_q    <= 1'b0;
            reg_clear_q  <= 1'b0;
            tile_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            read_en_q    <= 1'b0;
            reg_clear_q  <= 1'b0;
            tile_start_q <= 1'b0;
            done_q       <= 1'b0;

            if (state_q != ST_IDLE && i_abort) begin
                state_q     <= ST_IDLE;
                reg_clear_q <= 1'b1;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        busy_q <= i_start;
                        if (i_start) begin
                            cur_addr_q  <= i_base_addr;
                            len_q       <= i_tile_len;
                            stride_q    <= i_tile_stride;
                            num_tiles_q <= num_tiles_d;
                            tile_idx_q  <= '0;
                            reg_clear_q <= 1'b1;
                            if (num_tiles_d == '0) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_CLEAR;
                            end
                        end
                    end
                    ST_CLEAR: begin
                        state_q <= ST_WAIT_RDY;
                    end
                    ST_WAIT_RDY: begin
                        if (i_route_ready) begin
                            state_q      <= ST_READ;
                            read_en_q    <= 1'b1;
                            tile_start_q <= 1'b1;
                        end
                    end
                    ST_READ: begin
                        // A done flag from the previous tile cannot reach here:
                        // every READ is preceded by a CLEAR.
                        if (i_read_done) begin
                            if (last_tile) begin
                                state_q     <= ST_DONE;
                                done_q      <= 1'b1;
                                reg_clear_q <= 1'b1;
                            end else begin
                                state_q <= ST_NEXT;
                            end
                        end else begin
                            read_en_q <= 1'b1;
                        end
                    end
                    ST_NEXT: begin
                        cur_addr_q  <= cur_addr_d;
                        tile_idx_q  <= tile_idx_q + TILE_WIDTH'(1);
                        state_q     <= ST_CLEAR;
                        reg_clear_q <= 1'b1;
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_read_en    = read_en_q;
    assign o_reg_clear  = reg_clear_q;
    assign o_start_addr = cur_addr_q;
    assign o_addr_end   = len_q;
    assign o_tile_idx   = tile_idx_q;
    assign o_tile_start = tile_start_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_tile_read_sched.sv
// Scoreboard bench for tile_read_sched: expected tiles are queued at job start
// and compared on every o_tile_start; a small reader model answers o_read_en.
module tb_tile_read_sched;

    localparam int AW = 6;
    localparam int TW = 5;

    logic          i_clk = 1'b0;
    logic          i_rst, i_start, i_abort, i_route_ready, i_read_done;
    logic [AW-1:0] i_base_addr, i_tile_len, i_tile_stride;
    logic [TW-1:0] i_num_tiles;
    logic          o_read_en, o_reg_clear, o_tile_start, o_busy, o_done;
    logic [AW-1:0] o_start_addr, o_addr_end;
    logic [TW-1:0] o_tile_idx;

    tile_read_sched dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
        .i_base_addr(i_base_addr), .i_tile_len(i_tile_len),
        .i_tile_stride(i_tile_stride), .i_num_tiles(i_num_tiles),
        .i_route_ready(i_route_ready), .i_read_done(i_read_done),
        .o_read_en(o_read_en), .o_reg_clear(o_reg_clear),
        .o_start_addr(o_start_addr), .o_addr_end(o_addr_end),
        .o_tile_idx(o_tile_idx), .o_tile_start(o_tile_start),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [AW-1:0] len;
        logic [TW-1:0] idx;
    } tile_t;

    tile_t exp_q[$];
    tile_t mon_e;
    int n_cmp = 0, n_bad = 0;
    int n_tstart = 0, n_done = 0, n_clear = 0, n_ren = 0;
    int rd_lat = 4, rd_cnt = 0;
    int t0, d0, c0, r0;
    bit found;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    function automatic logic [31:0] outs();
        return 32'({o_read_en, o_reg_clear, o_start_addr, o_addr_end, o_tile_idx,
                    o_tile_start, o_busy, o_done});
    endfunction

    task automatic snap();
        t0 = n_tstart; d0 = n_done; c0 = n_clear; r0 = n_ren;
    endtask

    task automatic start_job(input int base, input int len, input int stride, input int num);
        tile_t t;
        int    eff;
        i_base_addr   = AW'(base);
        i_tile_len    = AW'(len);
        i_tile_stride = AW'(stride);
        i_num_tiles   = TW'(num);
        eff = (num > 16) ? 16 : num;
        for (int k = 0; k < eff; k++) begin
            t.addr = AW'(base + k * stride);
            t.len  = AW'(len);
            t.idx  = TW'(k);
            exp_q.push_back(t);
        end
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit   seen;
        logic rd_prev;
        seen    = 1'b0;
        rd_prev = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            rd_prev = i_read_done;
            tick();
            if (o_done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 1);
        if (seen) begin
            check({tag, "_done_after_rd"}, 32'(rd_prev), 1);
            check({tag, "_done_clear"}, 32'(o_reg_clear), 1);
        end
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_route_ready = 1'b1;
        i_read_done = 1'b0; i_base_addr = '0; i_tile_len = '0;
        i_tile_stride = '0; i_num_tiles = '0;

        fork
            // Tile reader model: done is sticky until cleared.
            forever begin
                @(posedge i_clk);
                #1;
                if (i_rst || o_reg_clear) begin
                    rd_cnt = 0;
                    i_read_done = 1'b0;
                end else if (o_read_en) begin
                    rd_cnt++;
                    if (rd_cnt >= rd_lat) i_read_done = 1'b1;
                end
            end
            // Monitor and scoreboard.
            forever begin
                @(negedge i_clk);
                if (o_tile_start) begin
                    n_tstart++;
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_tile", 32'(exp_q.size()), 1);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("sb_addr", 32'(o_start_addr), 32'(mon_e.addr));
                        check("sb_len", 32'(o_addr_end), 32'(mon_e.len));
                        check("sb_idx", 32'(o_tile_idx), 32'(mon_e.idx));
                    end
                end
                if (o_done) n_done++;
                if (o_reg_clear) n_clear++;
                if (o_read_en) n_ren++;
            end
        join_none

        tick(); tick(); tick();
        check("rst_outs", outs(), 0);
        i_rst = 1'b0;
        tick();

        // Single tile with reader latency 9 and exact start-up latency.
        rd_lat = 9; snap();
        start_job(4, 7, 0, 1);
        check("t1_clear", 32'(o_reg_clear), 1);
        check("t1_busy", 32'(o_busy), 1);
        tick();
        check("t1_wait_ren", 32'(o_read_en), 0);
        check("t1_wait_clear", 32'(o_reg_clear), 0);
        tick();
        check("t1_read_en", 32'(o_read_en), 1);
        check("t1_tile_start", 32'(o_tile_start), 1);
        wait_done("t1", 40);
        tick();
        check("t1_idle_busy", 32'(o_busy), 0);
        check("t1_n_tstart", 32'(n_tstart - t0), 1);
        check("t1_n_ren", 32'(n_ren - r0), 9);
        check("t1_n_clear", 32'(n_clear - c0), 2);
        check("t1_n_done", 32'(n_done - d0), 1);

        // Multi-tile with base wrap: 56, 0, 8.
        rd_lat = 2; snap();
        start_job(56, 3, 8, 3);
        wait_done("t2", 60);
        tick();
        check("t2_n_tstart", 32'(n_tstart - t0), 3);
        check("t2_n_clear", 32'(n_clear - c0), 4);
        check("t2_n_done", 32'(n_done - d0), 1);
        check("t2_sb_empty", 32'(exp_q.size()), 0);

        // Backpressure on tile 1.
        rd_lat = 3; snap();
        start_job(10, 2, 5, 2);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (o_reg_clear && o_busy && !o_done && o_tile_idx == TW'(1)) found = 1'b1;
            else tick();
        end
        check("t3_found_clear1", 32'(found), 1);
        if (found) begin
            i_route_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                tick();
                check("t3_hold_ren", 32'(o_read_en), 0);
                check("t3_hold_addr", 32'(o_start_addr), 15);
            end
            i_route_ready = 1'b1;
            tick();
            check("t3_read_en", 32'(o_read_en), 1);
            check("t3_tile_start", 32'(o_tile_start), 1);
        end
        i_route_ready = 1'b1;
        wait_done("t3", 40);
        tick();
        check("t3_n_tstart", 32'(n_tstart - t0), 2);
        check("t3_sb_empty", 32'(exp_q.size()), 0);

        // Empty job.
        snap();
        start_job(9, 1, 1, 0);
        check("t4_done", 32'(o_done), 1);
        check("t4_clear", 32'(o_reg_clear), 1);
        check("t4_ren", 32'(o_read_en), 0);
        tick();
        check("t4_idle_busy", 32'(o_busy), 0);
        check("t4_idle_done", 32'(o_done), 0);
        tick();
        check("t4_n_ren", 32'(n_ren - r0), 0);
        check("t4_n_done", 32'(n_done - d0), 1);

        // Start pulse and config changes while busy are ignored.
        rd_lat = 2; snap();
        start_job(0, 1, 3, 4);
        tick(); tick();
        i_base_addr = 6'd33; i_tile_len = 6'd9; i_tile_stride = 6'd1; i_num_tiles = 5'd1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_done("t5", 80);
        check("t5_len_kept", 32'(o_addr_end), 1);
        tick();
        check("t5_n_tstart", 32'(n_tstart - t0), 4);
        check("t5_n_done", 32'(n_done - d0), 1);
        check("t5_sb_empty", 32'(exp_q.size()), 0);

        // Abort in READ of tile 2 of 4, then a clean restart.
        rd_lat = 6; snap();
        start_job(20, 4, 1, 4);
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (o_read_en && o_tile_start && o_tile_idx == TW'(2)) found = 1'b1;
            else tick();
        end
        check("t6_found_read2", 32'(found), 1);
        if (found) begin
            i_abort = 1'b1;
            tick();
            i_abort = 1'b0;
            check("t6_busy", 32'(o_busy), 0);
            check("t6_clear", 32'(o_reg_clear), 1);
            check("t6_ren", 32'(o_read_en), 0);
            check("t6_done", 32'(o_done), 0);
            check("t6_sb_left", 32'(exp_q.size()), 1);
        end
        i_abort = 1'b0;
        exp_q.delete();
        tick(); tick();
        check("t6_no_done", 32'(n_done - d0), 0);
        start_job(7, 2, 4, 2);
        wait_done("t6b", 40);
        tick();
        check("t6b_sb_empty", 32'(exp_q.size()), 0);
        check("t6b_n_tstart", 32'(n_tstart - t0), 5);

        // Reset while waiting for the router.
        snap();
        i_route_ready = 1'b0;
        start_job(1, 1, 1, 3);
        tick();
        check("t7_in_wait", 32'(o_busy), 1);
        i_rst = 1'b1;
        tick();
        check("t7_rst_outs", outs(), 0);
        i_rst = 1'b0;
        check("t7_sb_left", 32'(exp_q.size()), 3);
        exp_q.delete();
        i_route_ready = 1'b1;
        tick();
        check("t7_idle", 32'(o_busy), 0);
        check("t7_no_done", 32'(n_done - d0), 0);

        // Tile count clamped to MAX_TILES.
        rd_lat = 1; snap();
        start_job(0, 0, 1, 20);
        wait_done("t8", 300);
        check("t8_last_idx", 32'(o_tile_idx), 15);
        tick();
        check("t8_n_tstart", 32'(n_tstart - t0), 16);
        check("t8_n_done", 32'(n_done - d0), 1);
        check("t8_sb_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
